johnson_seq_ctrl: RTL and testbench
===================================

// Module: johnson_seq_ctrl
// PURPOSE
//   Run/pause/step controller for the LED Johnson counter.
//   It owns a WIDTH-bit Johnson register and paces it with a clock-divider prescaler.
//   It decodes start/stop/step/clear commands, steps in either direction and tracks the phase index.
//   Sits between the board switches/buttons and the LED bank.
// PARAMETERS
//   WIDTH  4  Johnson register width; sequence length is 2*WIDTH phases
//   DIV    3  clk cycles per automatic step in RUN (>=1; 1 = step every cycle)
//   PW     $clog2(2*WIDTH)  phase index width (derived, do not override)
// PORTS
//   clk      in   1      single system clock, all logic on posedge
//   reset    in   1      synchronous, active-high
//   clear    in   1      sync clear of pattern/phase/FSM, level, sampled each cycle
//   start    in   1      enter/resume RUN (single-cycle pulse expected)
//   stop     in   1      RUN -> PAUSE
//   step     in   1      one manual step; honoured only in IDLE/PAUSE
//   dir      in   1      0 = up (shift toward MSB), 1 = down
//   leds     out  WIDTH  Johnson register contents
//   phase    out  PW     current phase, 0..2*WIDTH-1
//   running  out  1      1 while FSM is in RUN
//   wrap     out  1      one-cycle pulse, see BEHAVIOUR
// BEHAVIOUR
//   Reset: leds=0, phase=0, running=0, wrap=0, prescaler=0, FSM=IDLE; all outputs registered.
//   Command priority per cycle: reset > clear > stop > start > step.
//   Up step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}, phase <= (phase==2W-1) ? 0 : phase+1.
//   Down step: q <= {~q[0], q[WIDTH-1:1]}, phase <= (phase==0) ? 2W-1 : phase-1.
//   Register only reaches the 2*WIDTH legal Johnson codes.
//   FSM states:
//     IDLE:  start -> RUN. step -> advance one phase, stay IDLE.
//     RUN:   stop -> PAUSE. start and step are ignored.
//            Prescaler counts 0..DIV-1; when it reaches DIV-1, advance one step and reset the prescaler to 0.
//     PAUSE: start -> RUN. step -> advance one phase, stay PAUSE. stop is ignored.
//   Prescaler clears on every entry to RUN.
//     First automatic step: leds update exactly DIV cycles after the edge that enters RUN.
//     Held at its value in IDLE/PAUSE.
//   clear (any state): next edge gives leds=0, phase=0, prescaler=0, FSM=IDLE, wrap=0.
//   start+stop in the same cycle: stop wins (IDLE stays IDLE; RUN -> PAUSE).
//   dir is sampled on the cycle a step is taken; a change mid-RUN applies to the next step.
//   wrap is registered alongside leds and is high in the first cycle leds shows:
//     phase 0 after an up step from 2W-1, or
//     phase 2W-1 after a down step from 0.
//   Reset or clear mid-RUN aborts immediately; no step is taken on that edge.
// CONFIGURATION
//   JSC_BOUNCE_EN defined: ping-pong mode.
//     Internal dir_r is loaded from dir on leaving IDLE (start or step); the dir input is then ignored.
//     A step landing on phase 2W-1 while going up sets dir_r=down.
//     A step landing on phase 0 while going down sets dir_r=up.
//     Phase never wraps; wrap pulses at each reversal (leds shows phase 2W-1 or 0).
//     clear/reset return dir_r to up.
//   JSC_BOUNCE_EN undefined: direction follows the dir input per step; wrap-around as above.
// TESTING (WIDTH=4, DIV=3)
//   1. reset high 2 cycles -> leds=0000, phase=0, running=0, wrap=0.
//   2. start pulse, dir=0 -> running=1; every 3 cycles leds goes
//      0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 only in the 0000 cycle.
//   3. From 0000 in RUN, dir=1 -> 1000 (phase 7, wrap=1), 1100 (6), 1110 (5), ...
//   4. stop at phase 3 (0111) -> leds held 10 cycles, running=0.
//      step pulse -> 1111, phase 4. start -> next change (1110) exactly 3 cycles later.
//   5. start+stop same cycle in IDLE -> stays IDLE.
//      clear during RUN at phase 5 -> next cycle leds=0000, phase=0, running=0.
//   6. JSC_BOUNCE_EN, start with dir=0 -> phases 1..7, 6..0, 1...;
//      wrap=1 on reaching 7 and on reaching 0; no 7->0 transition ever.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// rtl/johnson_seq_ctrl.sv - run/pause/step controller for a WIDTH-bit LED Johnson counter
// Optional feature macro: JSC_BOUNCE_EN (ping-pong direction instead of wrap-around).
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 3,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] leds,
    output logic [PW-1:0]    phase,
    output logic             running,
    output logic             wrap
);

    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  LAST   = PW'(2 * WIDTH - 1);
    localparam logic [PSW-1:0] PS_TOP = PSW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [PSW-1:0]   presc_q, presc_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;
    logic             do_step;
    logic             step_dir;
`ifdef JSC_BOUNCE_EN
    logic             dir_q, dir_d;
`endif

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        phase_d  = phase_q;
        presc_d  = presc_q;
        wrap_d   = 1'b0;
        do_step  = 1'b0;
`ifdef JSC_BOUNCE_EN
        dir_d    = dir_q;
        step_dir = dir_q;
`else
        step_dir = dir;
`endif

        if (clear) begin
            state_d = ST_IDLE;
            q_d     = '0;
            phase_d = '0;
            presc_d = '0;
`ifdef JSC_BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else begin
            // stop outranks start and step in every state, even where stop itself does nothing
            case (state_q)
                ST_IDLE: begin
                    if (!stop) begin
                        if (start) begin
                            state_d = ST_RUN;
                            presc_d = '0;
`ifdef JSC_BOUNCE_EN
                            dir_d   = dir;
`endif
                        end else if (step) begin
                            do_step = 1'b1;
`ifdef JSC_BOUNCE_EN
                            dir_d    = dir;
                            step_dir = dir;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PS_TOP) begin
                        do_step = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PSW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!stop) begin
                        if (start) begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end else if (step) begin
                            do_step = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_step) begin
`ifdef JSC_BOUNCE_EN
                // Never step past an end in ping-pong mode; turn around instead.
                if (!step_dir && phase_q == LAST) begin
                    step_dir = 1'b1;
                end else if (step_dir && phase_q == '0) begin
                    step_dir = 1'b0;
                end
`endif
                if (!step_dir) begin
                    q_d     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                    phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
                end else begin
                    q_d     = {~q_q[0], q_q[WIDTH-1:1]};
                    phase_d = (phase_q == '0) ? LAST : phase_q - PW'(1);
                end
`ifdef JSC_BOUNCE_EN
                if (!step_dir && phase_d == LAST) begin
                    dir_d  = 1'b1;
                    wrap_d = 1'b1;
                end else if (step_dir && phase_d == '0) begin
                    dir_d  = 1'b0;
                    wrap_d = 1'b1;
                end
`else
                wrap_d = step_dir ? (phase_q == '0) : (phase_q == LAST);
`endif
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            q_q       <= '0;
            phase_q   <= '0;
            presc_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
`ifdef JSC_BOUNCE_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            phase_q   <= phase_d;
            presc_q   <= presc_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
`ifdef JSC_BOUNCE_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign leds    = q_q;
    assign phase   = phase_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb/tb_johnson_seq_ctrl.sv - self-checking bench for johnson_seq_ctrl (WIDTH=4, DIV=3)
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, clear, start, stop, step, dir;
    logic [3:0] leds;
    logic [2:0] phase;
    logic       running, wrap;

    int checks = 0;
    int errors = 0;

    johnson_seq_ctrl #(.WIDTH(4), .DIV(3)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop),
        .step(step), .dir(dir), .leds(leds), .phase(phase), .running(running),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr, sta, sto, stp, d;
        logic [3:0] leds;
        logic [2:0] ph;
        logic       run, wr;
    } vec_t;

    typedef struct {
        logic [3:0] leds;
        logic [2:0] ph;
        logic       run, wr;
        string      name;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[29];

    function automatic logic [3:0] jc(input int p);
        int v;
        v = (p <= 4) ? ((1 << p) - 1) : ((15 << (p - 4)) & 15);
        return v[3:0];
    endfunction

    function automatic vec_t mk(input logic c, s, t, p, d, input logic [3:0] l,
                                input int ph, input logic r, w);
        vec_t v;
        v.clr = c; v.sta = s; v.sto = t; v.stp = p; v.d = d;
        v.leds = l; v.ph = 3'(ph); v.run = r; v.wr = w;
        return v;
    endfunction

    task automatic drive(input logic rst, c, s, t, p, d,
                         input logic [3:0] el, input int eph, input logic er, ew,
                         input string nm);
        exp_t e, got;
        reset = rst; clear = c; start = s; stop = t; step = p; dir = d;
        e.leds = el; e.ph = 3'(eph); e.run = er; e.wr = ew; e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        checks++;
        if (leds !== got.leds || phase !== got.ph || running !== got.run || wrap !== got.wr) begin
            errors++;
            $display("FAIL %s: got leds=%b phase=%0d running=%b wrap=%b, expected leds=%b phase=%0d running=%b wrap=%b",
                     got.name, leds, phase, running, wrap, got.leds, got.ph, got.run, got.wr);
        end
    endtask

    initial begin
        int p;
        logic d;
        logic w;

        reset = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "reset_0");
        drive(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "reset_1");

`ifdef JSC_BOUNCE_EN
        drive(0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, "bounce_start");
        p = 0; d = 1'b0;
        for (int s = 0; s < 16; s++) begin
            drive(0, 0, 0, 0, 0, 1'($urandom_range(1)), jc(p), p, 1, 0, "bounce_hold");
            drive(0, 0, 0, 0, 0, 1'($urandom_range(1)), jc(p), p, 1, 0, "bounce_hold");
            w = 1'b0;
            if (!d) begin
                p = p + 1;
                if (p == 7) begin d = 1'b1; w = 1'b1; end
            end else begin
                p = p - 1;
                if (p == 0) begin d = 1'b0; w = 1'b1; end
            end
            drive(0, 0, 0, 0, 0, 1'($urandom_range(1)), jc(p), p, 1, w, "bounce_step");
        end
`else
        // {clear, start, stop, step, dir} -> {leds, phase, running, wrap} after the edge
        tbl[0]  = mk(0, 0, 0, 1, 0, 4'b0001, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 4'b0001, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 4'b0011, 2, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 1, 4'b0001, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 1, 4'b0000, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 4'b1000, 7, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 4'b1000, 7, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 4'b0000, 0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 0, 0, 4'b0000, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 4'b0001, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 4'b0001, 1, 1, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 4'b0001, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 4'b0011, 2, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 4'b0011, 2, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 4'b0011, 2, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'b0111, 3, 1, 0);
        tbl[20] = mk(0, 0, 1, 0, 0, 4'b0111, 3, 0, 0);
        tbl[21] = mk(0, 1, 1, 0, 0, 4'b0111, 3, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 0, 4'b1111, 4, 0, 0);
        tbl[23] = mk(0, 1, 0, 0, 0, 4'b1111, 4, 1, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 4'b1111, 4, 1, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 4'b1111, 4, 1, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 4'b1110, 5, 1, 0);
        tbl[27] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(0, tbl[i].clr, tbl[i].sta, tbl[i].sto, tbl[i].stp, tbl[i].d,
                  tbl[i].leds, int'(tbl[i].ph), tbl[i].run, tbl[i].wr, $sformatf("vec_%0d", i));
        end

        // Full up lap in RUN with wrap on the return to 0000.
        drive(0, 0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, "run_start");
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 0, 0, 0, jc(k - 1), k - 1, 1, 0, "run_up_hold");
            drive(0, 0, 0, 0, 0, 0, jc(k - 1), k - 1, 1, 0, "run_up_hold");
            drive(0, 0, 0, 0, 0, 0, jc(k % 8), k % 8, 1, (k == 8), "run_up_step");
        end

        // Reverse mid-RUN from phase 0: wraps to 7 on the first down step.
        p = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, jc(p), p, 1, 0, "run_dn_hold");
            drive(0, 0, 0, 0, 0, 1, jc(p), p, 1, 0, "run_dn_hold");
            p = (p + 7) % 8;
            drive(0, 0, 0, 0, 0, 1, jc(p), p, 1, (p == 7), "run_dn_step");
        end

        drive(0, 0, 0, 1, 0, 0, jc(p), p, 0, 0, "pause_enter");
        for (int k = 0; k < 10; k++)
            drive(0, 0, 0, 0, 0, 0, jc(p), p, 0, 0, "pause_hold");

        drive(0, 0, 1, 0, 0, 0, jc(p), p, 1, 0, "resume");
        drive(0, 0, 0, 0, 0, 0, jc(p), p, 1, 0, "resume_hold");
        drive(0, 0, 0, 0, 0, 0, jc(p), p, 1, 0, "resume_hold");
        drive(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "reset_mid_run");
        drive(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "after_reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
